rca_pipe_adder: RTL

RCA_PIPE_ADDER -- requirements
Module: rca_pipe_adder

---
 rtl/rca_pipe_adder.sv | 116 +++++++++++
 1 files changed

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder: one SEG_WIDTH slice per registered stage, valid/ready flow control.
// Define RCA_PIPE_OVF_EN to add the o_overflow output (signed overflow of the WIDTH-bit sum).
module rca_pipe_adder #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned SEG_WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_busy
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int unsigned NUM_SEG = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  // Operands are zero-padded to whole segments so every stage slices a uniform SEG_WIDTH field.
  localparam int unsigned PW      = NUM_SEG * SEG_WIDTH;

  logic [NUM_SEG-1:0] v;
  logic [NUM_SEG-1:0] v_in;
  logic [NUM_SEG:0]   load;

  logic [PW-1:0] a_r  [NUM_SEG];
  logic [PW-1:0] b_r  [NUM_SEG];
  logic [PW-1:0] s_r  [NUM_SEG];
  logic          c_r  [NUM_SEG];
  logic [PW-1:0] a_in [NUM_SEG];
  logic [PW-1:0] b_in [NUM_SEG];
  logic [PW-1:0] s_in [NUM_SEG];
  logic          c_in [NUM_SEG];
  logic [PW-1:0] s_nx [NUM_SEG];
  logic          c_nx [NUM_SEG];
  logic [SEG_WIDTH:0] seg;

  always_comb begin
    // A stage may load when it is empty or its successor is loading; the output stage drains on i_ready.
    load[NUM_SEG] = i_ready;
    for (int unsigned k = NUM_SEG; k > 0; k--) begin
      load[k-1] = !v[k-1] || load[k];
    end

    v_in[0] = i_valid;
    a_in[0] = PW'(i_add_term1);
    b_in[0] = PW'(i_add_term2);
    s_in[0] = '0;
    c_in[0] = i_carry;
    for (int unsigned k = 1; k < NUM_SEG; k++) begin
      v_in[k] = v[k-1];
      a_in[k] = a_r[k-1];
      b_in[k] = b_r[k-1];
      s_in[k] = s_r[k-1];
      c_in[k] = c_r[k-1];
    end

    seg = '0;
    for (int unsigned k = 0; k < NUM_SEG; k++) begin
      seg = {1'b0, a_in[k][k*SEG_WIDTH +: SEG_WIDTH]}
          + {1'b0, b_in[k][k*SEG_WIDTH +: SEG_WIDTH]}
          + (SEG_WIDTH+1)'(c_in[k]);
      s_nx[k] = s_in[k];
      s_nx[k][k*SEG_WIDTH +: SEG_WIDTH] = seg[SEG_WIDTH-1:0];
      c_nx[k] = seg[SEG_WIDTH];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v <= '0;
      for (int unsigned k = 0; k < NUM_SEG; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
        c_r[k] <= 1'b0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_SEG; k++) begin
        if (load[k]) begin
          v[k]   <= v_in[k];
          a_r[k] <= a_in[k];
          b_r[k] <= b_in[k];
          s_r[k] <= s_nx[k];
          c_r[k] <= c_nx[k];
        end
      end
    end
  end

  assign o_valid = v[NUM_SEG-1];
  assign o_ready = load[0];
  assign o_busy  = |v;

  // With padding the carry-out already sits at bit WIDTH of the padded sum.
  generate
    if (PW > WIDTH) begin : g_padded
      assign o_result = s_r[NUM_SEG-1][WIDTH:0];
    end else begin : g_exact
      assign o_result = {c_r[NUM_SEG-1], s_r[NUM_SEG-1]};
    end
  endgenerate

`ifdef RCA_PIPE_OVF_EN
  // Carry into the MSB recovered as a ^ b ^ sum at that bit, then XORed with the carry-out.
  assign o_overflow = a_r[NUM_SEG-1][WIDTH-1] ^ b_r[NUM_SEG-1][WIDTH-1]
                    ^ s_r[NUM_SEG-1][WIDTH-1] ^ o_result[WIDTH];
`endif

endmodule
